// File: rtl/md_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Optional feature macro used by the top: MD_SINGLE_CYCLE_MUL_EN.
package md_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    localparam logic MD_OP_MUL = 1'b0;
    localparam logic MD_OP_DIV = 1'b1;

    // Bits needed to count 0..value-1 (minimum 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_div_iter_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface mult_div_iter_if #(parameter int unsigned WIDTH = 32);

    logic             start;
    logic             op_div;
    logic             is_signed;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             div_by_zero;

    modport master (
        output start, op_div, is_signed, src1, src2, cancel,
        input  busy, done, result_hi, result_lo, div_by_zero
    );

    modport slave (
        input  start, op_div, is_signed, src1, src2, cancel,
        output busy, done, result_hi, result_lo, div_by_zero
    );

endinterface

// File: rtl/md_div_step.sv
// One combinational restoring-divide step: shift in a dividend bit, trial-subtract.
module md_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_in[WIDTH-1:0], dividend_bit};
        diff    = shifted - {1'b0, divisor};
        // A set top bit means the true shifted value exceeds any WIDTH-bit divisor.
        q_bit   = rem_in[WIDTH] | (shifted >= {1'b0, divisor});
        rem_out = q_bit ? diff : shifted;
    end

endmodule

// File: rtl/mult_div_iter.sv
// WIDTH-generic iterative multiply/divide with start/busy/done handshake and cancel.
// Define MD_SINGLE_CYCLE_MUL_EN for a single registered multiplier (IDLE -> DONE).
module mult_div_iter
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_iter_if.slave bus
);

    localparam int unsigned CW = clog2(WIDTH);

    md_state_e state_q, state_d;

    logic [CW-1:0]      cnt_q;
    logic               op_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               dz_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   src1_raw_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH:0]     rem_q;

    logic [WIDTH-1:0]   res_hi_q;
    logic [WIDTH-1:0]   res_lo_q;
    logic               res_dz_q;

    logic               accept;
    logic               last_iter;
    logic               busy;
    logic               done;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_nx;
    logic               q_bit;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

`ifdef MD_SINGLE_CYCLE_MUL_EN
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod_sc;

    // Low 2*WIDTH bits of the extended product are right for both sign modes.
    always_comb begin
        a_ext   = {{WIDTH{bus.is_signed & bus.src1[WIDTH-1]}}, bus.src1};
        b_ext   = {{WIDTH{bus.is_signed & bus.src2[WIDTH-1]}}, bus.src2};
        prod_sc = a_ext * b_ext;
    end
`endif

    assign accept    = (state_q == IDLE) && bus.start && !bus.cancel;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        a_neg = bus.is_signed & bus.src1[WIDTH-1];
        b_neg = bus.is_signed & bus.src2[WIDTH-1];
        a_mag = a_neg ? -bus.src1 : bus.src1;
        b_mag = b_neg ? -bus.src2 : bus.src2;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef MD_SINGLE_CYCLE_MUL_EN
                    state_d = (bus.op_div == MD_OP_DIV) ? CALC : DONE;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC:    if (last_iter) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.cancel) state_d = IDLE;
    end

    // Multiply keeps multiplier in acc low half and shifts the sum in from the top.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    end

    md_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in       (rem_q),
        .divisor      (opnd_q),
        .dividend_bit (acc_q[WIDTH-1]),
        .rem_out      (rem_nx),
        .q_bit        (q_bit)
    );

    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            op_q       <= MD_OP_MUL;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            opnd_q     <= '0;
            src1_raw_q <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            res_hi_q   <= '0;
            res_lo_q   <= '0;
            res_dz_q   <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q      <= '0;
                op_q       <= bus.op_div;
                neg_res_q  <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                dz_q       <= (bus.src2 == '0);
                src1_raw_q <= bus.src1;
                rem_q      <= '0;
                if (bus.op_div == MD_OP_DIV) begin
                    opnd_q <= b_mag;
                    acc_q  <= {{WIDTH{1'b0}}, a_mag};
                end else begin
                    opnd_q <= a_mag;
                    acc_q  <= {{WIDTH{1'b0}}, b_mag};
                end
`ifdef MD_SINGLE_CYCLE_MUL_EN
                if (bus.op_div == MD_OP_MUL) begin
                    res_hi_q <= prod_sc[2*WIDTH-1:WIDTH];
                    res_lo_q <= prod_sc[WIDTH-1:0];
                    res_dz_q <= 1'b0;
                end
`endif
            end else if (state_q == CALC) begin
                cnt_q <= last_iter ? '0 : cnt_q + 1'b1;
                if (op_q == MD_OP_DIV) begin
                    rem_q <= rem_nx;
                    acc_q <= {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], q_bit};
                end else begin
                    acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                end
            end else if ((state_q == FIX) && !bus.cancel) begin
                if (op_q == MD_OP_MUL) begin
                    res_hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                    res_lo_q <= prod_fix[WIDTH-1:0];
                    res_dz_q <= 1'b0;
                end else if (dz_q) begin
                    res_hi_q <= src1_raw_q;
                    res_lo_q <= '1;
                    res_dz_q <= 1'b1;
                end else begin
                    res_hi_q <= rem_fix;
                    res_lo_q <= quo_fix;
                    res_dz_q <= 1'b0;
                end
            end
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.result_hi   = res_hi_q;
    assign bus.result_lo   = res_lo_q;
    assign bus.div_by_zero = res_dz_q;

endmodule

// File: tb/tb_mult_div_iter.sv
// Self-checking bench for mult_div_iter against a plain-arithmetic reference model.
module tb_mult_div_iter;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mult_div_iter_if #(.WIDTH(W)) bus ();

    mult_div_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;
    logic         last_dz = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic op, input logic sg, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] hi,
                                  output logic [W-1:0] lo, output logic dz);
        logic [63:0] p;
        longint sa, sb;
        int ia, ib;
        dz = 1'b0;
        if (!op) begin
            if (sg) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
            end else begin
                p = {32'b0, a} * {32'b0, b};
            end
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 0) begin
            hi = a;
            lo = '1;
            dz = 1'b1;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            hi = '0;
            lo = 32'h8000_0000;
        end else if (sg) begin
            ia = $signed(a);
            ib = $signed(b);
            lo = 32'(ia / ib);
            hi = 32'(ia % ib);
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    // Caller is at a negedge with the unit idle; returns at the negedge after done.
    task automatic run_op(input logic op, input logic sg, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int unsigned poke, input string tag);
        logic [W-1:0] eh, el;
        logic         ed;
        int unsigned  lat;
        model(op, sg, a, b, eh, el, ed);
        lat = W + 2;
`ifdef MD_SINGLE_CYCLE_MUL_EN
        if (!op) lat = 1;
`endif
        bus.start = 1'b1;
        bus.op_div = op;
        bus.is_signed = sg;
        bus.src1 = a;
        bus.src2 = b;
        @(negedge clk);
        for (int unsigned c = 1; c <= lat; c++) begin
            bus.start = 1'b0;
            bus.src1 = $urandom;
            bus.src2 = $urandom;
            bus.op_div = 1'($urandom_range(0, 1));
            if (c == poke) bus.start = 1'b1;
            chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
            chk({tag, "_done"}, 64'(bus.done), (c == lat) ? 64'd1 : 64'd0);
            if (c == lat) begin
                chk({tag, "_hi"}, 64'(bus.result_hi), 64'(eh));
                chk({tag, "_lo"}, 64'(bus.result_lo), 64'(el));
                chk({tag, "_dz"}, 64'(bus.div_by_zero), 64'(ed));
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
        chk({tag, "_nodone"}, 64'(bus.done), 64'd0);
        chk({tag, "_hold"}, {bus.result_hi, bus.result_lo}, {eh, el});
        last_hi = eh;
        last_lo = el;
        last_dz = ed;
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic op, sg;
        int unsigned kind;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.op_div = 1'b0;
        bus.is_signed = 1'b0;
        bus.src1 = '0;
        bus.src2 = '0;
        bus.cancel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_res", {bus.result_hi, bus.result_lo}, 64'd0);
        chk("rst_dz", 64'(bus.div_by_zero), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "umul_max");
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, "sdiv_m7_2");
        run_op(1'b1, 1'b0, 32'd5, 32'd0, 0, "udiv_zero");
        run_op(1'b1, 1'b1, 32'd5, 32'd0, 0, "sdiv_zero");
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "sdiv_ovf");
        run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 0, "smul_m3_5");
        run_op(1'b1, 1'b0, 32'd1000, 32'd7, 5, "div_poke");

        // Cancel during CALC iteration 10 (cycle 11), then restart immediately.
        bus.start = 1'b1;
        bus.op_div = 1'b1;
        bus.is_signed = 1'b0;
        bus.src1 = 32'd12345;
        bus.src2 = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        chk("cancel_busy", 64'(bus.busy), 64'd0);
        chk("cancel_done", 64'(bus.done), 64'd0);
        chk("cancel_res", {bus.result_hi, bus.result_lo}, {last_hi, last_lo});
        chk("cancel_dz", 64'(bus.div_by_zero), 64'(last_dz));
        run_op(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd9, 0, "after_cancel");

        bus.start = 1'b1;
        bus.cancel = 1'b1;
        bus.op_div = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.cancel = 1'b0;
        chk("startcancel_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("startcancel_done", 64'(bus.done), 64'd0);
        chk("startcancel_res", {bus.result_hi, bus.result_lo}, {last_hi, last_lo});

        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 7);
            op = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (kind == 0) begin
                b = '0;
                op = 1'b1;
            end else if (kind == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (kind == 2) begin
                a = 32'($urandom_range(0, 300)) - 32'd150;
                b = 32'($urandom_range(1, 20));
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            run_op(op, sg, a, b, 0, "rand");
        end

        // Reset in the middle of a divide clears everything with no done.
        bus.start = 1'b1;
        bus.op_div = 1'b1;
        bus.is_signed = 1'b0;
        bus.src1 = 32'd77;
        bus.src2 = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_res", {bus.result_hi, bus.result_lo}, 64'd0);
        chk("midrst_dz", 64'(bus.div_by_zero), 64'd0);
        run_op(1'b0, 1'b0, 32'd123456, 32'd654321, 0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_div_iter.md
# mult_div_iter

Parametrised iterative multiply/divide unit for the execute stage. It replaces the fixed 32-bit mult/div path with a WIDTH-generic engine that has explicit start/busy/done handshaking, exception-driven cancellation and divide-by-zero reporting. Results follow HI/LO convention and feed the writeback HI/LO registers. `busy` drives the hazard unit's execute-busy stall.

## Interface
- WIDTH, 32, operand width in bits; must be ≥4 and even.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch request; accepted only in IDLE.
- op_div  in  1  0 = multiply, 1 = divide; sampled with start.
- is_signed  in  1  two's-complement operands when 1; sampled with start.
- src1  in  WIDTH  multiplicand / dividend.
- src2  in  WIDTH  multiplier / divisor.
- cancel  in  1  exception flush; aborts any operation in flight.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; results valid in that cycle.
- result_hi  out  WIDTH  product high half / remainder.
- result_lo  out  WIDTH  product low half / quotient.
- div_by_zero  out  1  set with done when a divide had src2 = 0; held with results.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: on start && !cancel, latch op, sign mode, operand magnitudes (negate if signed and MSB set), result signs; clear iteration counter; go to CALC.
- CALC: one radix-2 step per cycle for exactly WIDTH cycles (counter 0..WIDTH-1), then FIX.
  - Multiply: shift-add over a 2·WIDTH accumulator.
  - Divide: restoring step, partial remainder WIDTH+1 bits.
- FIX: apply sign correction, then write result_hi/result_lo/div_by_zero. Go to DONE.
  - Product sign = s1 ^ s2.
  - Quotient sign = s1 ^ s2.
  - Remainder sign = dividend sign.
- DONE: done = 1 for one cycle, then IDLE. start in DONE is ignored.
- Divide by zero: no correction. result_lo = all ones, result_hi = src1 as presented, div_by_zero = 1.
- Signed overflow (−2^(WIDTH−1) / −1): result_lo = 100…0, result_hi = 0, div_by_zero = 0.
- Results and div_by_zero hold their values until the next FIX writes them. A cancelled operation never updates them.
- cancel in any state: next state IDLE, no done pulse.
  - cancel with start in the same IDLE cycle: cancel wins; the operation is not accepted.
- start while busy: ignored; caller must hold or re-issue.

## Timing
- Reset: state IDLE, busy 0, done 0, result_hi 0, result_lo 0, div_by_zero 0, counter 0.
- Let cycle 0 be the start-accept cycle. busy is high in cycles 1..WIDTH+2 and done is high in cycle WIDTH+2 (cycle 34 for WIDTH=32).
- Next start is accepted in cycle WIDTH+3 at the earliest.
- cancel sampled in cycle k: busy is low in k+1.
- reset mid-operation: same as reset values next cycle; no done.

## Configuration
- MD_SINGLE_CYCLE_MUL_EN defined:
  - Multiply computes a full signed/unsigned product with a single registered multiplier in the accept cycle and goes IDLE → DONE directly.
  - busy and done are high in cycle 1; divide is unchanged.
- Undefined: multiply uses the iterative CALC/FIX path, with identical latency to divide.

## Structure
- Shared package md_pkg:
  - state enum (IDLE, CALC, FIX, DONE);
  - op encodings MD_OP_MUL = 0, MD_OP_DIV = 1;
  - counter width function clog2(WIDTH).
- One sub-module, md_div_step: a combinational restoring-divide step.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new partial remainder, quotient bit.

## Test plan
- Unsigned multiply, WIDTH=32, 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001; done exactly in cycle 34; busy high in cycles 1–34.
- Signed divide −7 / 2 (0xFFFFFFF9, 0x00000002) → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF, div_by_zero = 0.
- Divide 5 / 0, unsigned and signed → lo = 0xFFFFFFFF, hi = 0x00000005, div_by_zero = 1.
- Signed 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0x00000000, no flag.
- Cancel in CALC iteration 10 → busy low next cycle, no done, results keep the previous operation's values; a fresh start next cycle completes correctly. start+cancel in IDLE is not accepted.
- MD_SINGLE_CYCLE_MUL_EN: signed −3 × 5 → done in cycle 1, hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. A start pulse during a concurrent divide is ignored.
